// File: rtl/processor_core.sv
// processor_core: single-cycle 32-bit RISC core with internal instruction ROM
module processor_core #(
    parameter int IMEM_DEPTH = 64,
    parameter logic [IMEM_DEPTH*32-1:0] ROM_IMAGE = {
        {(IMEM_DEPTH-7){32'h0}},
        32'hF000_0000, 32'hE011_0000, 32'h9030_0000, 32'h2421_0000,
        32'h1312_0000, 32'h6200_0003, 32'h6100_0005
    }
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in_data,
    input  logic        start,
    output logic [31:0] IM_ADDRESS_BUS_main,
    output logic [31:0] IM_DATA_BUS_main,
    output logic [31:0] PC,
    output logic [31:0] wb_data_out_main,
    output logic [3:0]  flag_main,
    output logic [31:0] io_out
);
    localparam int AW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
    logic [IMEM_DEPTH-1:0][31:0] rom;
    logic [31:0] regs [16];
    logic [31:0] instr, a, b, bop, simm, res, pc_next;
    logic [32:0] sum;
    logic [3:0]  op, rd, rs1, rs2;
    logic        we, fa, fnz, halted, sub_op, n, z, v;

    assign rom                 = ROM_IMAGE;
    assign instr               = (PC < 32'(IMEM_DEPTH)) ? rom[PC[AW-1:0]] : 32'h0;
    assign {op, rd, rs1, rs2}  = instr[31:16];
    assign simm                = {{16{instr[15]}}, instr[15:0]};
    assign a                   = regs[rs1];
    assign b                   = regs[rs2];
    assign IM_ADDRESS_BUS_main = PC;
    assign IM_DATA_BUS_main    = instr;

    // SUB/CMP share the adder as a + ~b + 1 so carry-out means "no borrow"
    assign sub_op = (op == 4'h2) || (op == 4'hE);
    assign bop    = (op == 4'h6) ? simm : sub_op ? ~b : b;
    assign sum    = {1'b0, a} + {1'b0, bop} + {32'h0, sub_op};
    assign n      = res[31];
    assign z      = (res == 32'h0);
    assign v      = (a[31] == bop[31]) && (sum[31] != a[31]);

    assign pc_next = (op == 4'hB || (op == 4'hA && flag_main[2])) ? {16'h0, instr[15:0]} : PC + 32'd1;
    assign wb_data_out_main = (reset || start || halted || !we) ? 32'h0 : res;

    // result, register-write enable and flag-update class per opcode
    always_comb begin
        res = sum[31:0];
        we  = 1'b0;
        fa  = 1'b0;
        fnz = 1'b0;
        case (op)
            4'h1, 4'h2, 4'h6: begin we = 1'b1; fa = 1'b1; end
            4'hE: fa = 1'b1;
            4'h3: begin res = a & b; we = 1'b1; fnz = 1'b1; end
            4'h4: begin res = a | b; we = 1'b1; fnz = 1'b1; end
            4'h5: begin res = a ^ b; we = 1'b1; fnz = 1'b1; end
            4'h7: begin res = {instr[15:0], 16'h0}; we = 1'b1; end
            4'h8: begin res = in_data; we = 1'b1; end
            4'hC: begin res = a << b[4:0]; we = 1'b1; fnz = 1'b1; end
            4'hD: begin res = a >> b[4:0]; we = 1'b1; fnz = 1'b1; end
            default: ;
        endcase
    end

    // architectural state commit; halt freezes everything until reset or start
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) regs[i] <= 32'h0;
            PC        <= 32'h0;
            flag_main <= 4'h0;
            io_out    <= 32'h0;
            halted    <= 1'b0;
        end else if (start) begin
            PC     <= 32'h0;
            halted <= 1'b0;
        end else if (!halted) begin
            if (we && rd != 4'h0) regs[rd] <= res;
            if (fa) flag_main <= {n, z, sum[32], v};
            else if (fnz) flag_main[3:2] <= {n, z};
            if (op == 4'h9) io_out <= a;
            if (op == 4'hF) halted <= 1'b1;
            else PC <= pc_next;
        end
    end
endmodule

// File: tb/tb_processor_core.sv
// tb_processor_core: table-driven check of the default program and an IN/OUT/BZ program
module tb_processor_core;
    typedef struct {
        logic        r;
        logic        s;
        logic [31:0] pc;
        logic [31:0] ins;
        logic [31:0] wb;
        logic [3:0]  fl;
        logic [31:0] io;
    } vec_t;

    localparam logic [64*32-1:0] ROM1 = {{60{32'h0}}, 32'hA000_0000, 32'h1600_0000, 32'h9050_0000, 32'h8500_0000};

    logic        clk = 1'b0;
    logic        rst0, st0, rst1, st1;
    logic [31:0] in0, in1;
    logic [31:0] adr0, dat0, pc0, wb0, io0, adr1, dat1, pc1, wb1, io1;
    logic [3:0]  fl0, fl1;
    int          n_cmp = 0;
    int          n_err = 0;
    vec_t        t0[$];
    vec_t        t1[$];

    processor_core #(.IMEM_DEPTH(64)) u0 (
        .clk(clk), .reset(rst0), .in_data(in0), .start(st0),
        .IM_ADDRESS_BUS_main(adr0), .IM_DATA_BUS_main(dat0), .PC(pc0),
        .wb_data_out_main(wb0), .flag_main(fl0), .io_out(io0)
    );

    processor_core #(.IMEM_DEPTH(64), .ROM_IMAGE(ROM1)) u1 (
        .clk(clk), .reset(rst1), .in_data(in1), .start(st1),
        .IM_ADDRESS_BUS_main(adr1), .IM_DATA_BUS_main(dat1), .PC(pc1),
        .wb_data_out_main(wb1), .flag_main(fl1), .io_out(io1)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic s, input logic [31:0] pc, input logic [31:0] ins,
                                input logic [31:0] wb, input logic [3:0] fl, input logic [31:0] io);
        mk = '{r: r, s: s, pc: pc, ins: ins, wb: wb, fl: fl, io: io};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // drive one cycle's inputs on the falling edge and check the pre-commit view
    task automatic apply(input bit sel, input vec_t v);
        @(negedge clk);
        if (sel) begin rst1 = v.r; st1 = v.s; end
        else begin rst0 = v.r; st0 = v.s; end
        #1;
        chk("pc",    sel ? pc1 : pc0, v.pc);
        chk("addr",  sel ? adr1 : adr0, v.pc);
        chk("instr", sel ? dat1 : dat0, v.ins);
        chk("wb",    sel ? wb1 : wb0, v.wb);
        chk("flags", {28'h0, sel ? fl1 : fl0}, {28'h0, v.fl});
        chk("io",    sel ? io1 : io0, v.io);
    endtask

    initial begin
        rst0 = 1'b1; st0 = 1'b0; in0 = 32'h1234_5678;
        rst1 = 1'b1; st1 = 1'b0; in1 = 32'h0;
        // default program: run, halt, restart, then reset+start mid-run
        t0.push_back(mk(0, 0, 0, 32'h6100_0005, 32'h5,         4'h0, 32'h0));
        t0.push_back(mk(0, 0, 1, 32'h6200_0003, 32'h3,         4'h0, 32'h0));
        t0.push_back(mk(0, 0, 2, 32'h1312_0000, 32'h8,         4'h0, 32'h0));
        t0.push_back(mk(0, 0, 3, 32'h2421_0000, 32'hFFFF_FFFE, 4'h0, 32'h0));
        t0.push_back(mk(0, 0, 4, 32'h9030_0000, 32'h0,         4'h8, 32'h0));
        t0.push_back(mk(0, 0, 5, 32'hE011_0000, 32'h0,         4'h8, 32'h8));
        t0.push_back(mk(0, 0, 6, 32'hF000_0000, 32'h0,         4'h6, 32'h8));
        t0.push_back(mk(0, 1, 6, 32'hF000_0000, 32'h0,         4'h6, 32'h8));
        t0.push_back(mk(0, 0, 0, 32'h6100_0005, 32'h5,         4'h6, 32'h8));
        t0.push_back(mk(0, 0, 1, 32'h6200_0003, 32'h3,         4'h0, 32'h8));
        t0.push_back(mk(0, 0, 2, 32'h1312_0000, 32'h8,         4'h0, 32'h8));
        t0.push_back(mk(1, 1, 3, 32'h2421_0000, 32'h0,         4'h0, 32'h8));
        t0.push_back(mk(0, 0, 0, 32'h6100_0005, 32'h5,         4'h0, 32'h0));
        t0.push_back(mk(0, 0, 1, 32'h6200_0003, 32'h3,         4'h0, 32'h0));
        // IN/OUT/ADD/BZ loop with a reset+start in the middle
        t1.push_back(mk(0, 0, 0, 32'h8500_0000, 32'hDEAD_BEEF, 4'h0, 32'h0));
        t1.push_back(mk(0, 0, 1, 32'h9050_0000, 32'h0,         4'h0, 32'h0));
        t1.push_back(mk(0, 0, 2, 32'h1600_0000, 32'h0,         4'h0, 32'hDEAD_BEEF));
        t1.push_back(mk(0, 0, 3, 32'hA000_0000, 32'h0,         4'h4, 32'hDEAD_BEEF));
        t1.push_back(mk(0, 0, 0, 32'h8500_0000, 32'hDEAD_BEEF, 4'h4, 32'hDEAD_BEEF));
        t1.push_back(mk(0, 0, 1, 32'h9050_0000, 32'h0,         4'h4, 32'hDEAD_BEEF));
        t1.push_back(mk(1, 1, 2, 32'h1600_0000, 32'h0,         4'h4, 32'hDEAD_BEEF));
        t1.push_back(mk(0, 0, 0, 32'h8500_0000, 32'hDEAD_BEEF, 4'h0, 32'h0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_pc",    pc0, 32'h0);
        chk("rst_wb",    wb0, 32'h0);
        chk("rst_flags", {28'h0, fl0}, 32'h0);
        chk("rst_io",    io0, 32'h0);
        chk("rst_instr", dat0, 32'h6100_0005);
        for (int i = 0; i < t0.size(); i++) begin
            if (i == 7) begin
                repeat (10) begin
                    @(negedge clk);
                    #1;
                    chk("halt_pc", pc0, 32'h6);
                    chk("halt_wb", wb0, 32'h0);
                    chk("halt_io", io0, 32'h8);
                end
            end
            apply(1'b0, t0[i]);
        end
        @(negedge clk);
        #1;
        chk("u1_rst_wb", wb1, 32'h0);
        chk("u1_rst_io", io1, 32'h0);
        in1 = 32'hDEAD_BEEF;
        for (int i = 0; i < t1.size(); i++) apply(1'b1, t1[i]);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
